pc_fetch_ctrl: RTL and testbench

Parametrised program-counter and next-PC unit for the single-cycle/pipelined CPU datapath. It generalises the fixed 64-bit PC/branch logic in three ways: configurable widths for the PC and both branch-offset fields, a stall input, and a circular return-address stack (RAS) for branch-with-link and return. It drives the instruction-memory address and is controlled by the decode/flag logic.

---
 rtl/pc_fetch_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- program counter and next-PC selection with a circular
// return-address stack (RAS) for branch-with-link / return.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   stall          freeze PC and RAS for this cycle
//   brTaken        take a branch (PC-relative)
//   uncondBr       1: use brAddr26 offset, 0: use condAddr19 offset
//   link           with a taken unconditional branch, push the return address
//   ret            load PC from the RAS top (or fall through if empty)
//   condAddr19     signed word offset, conditional branches
//   brAddr26       signed word offset, unconditional branches
//   pc             registered current PC (instruction-memory address)
//   ras_empty      RAS holds no entries
//   ras_full       RAS holds RAS_DEPTH entries
//   ras_underflow  one-cycle registered pulse after a ret on an empty RAS
//
// Optional build macro BR_STATS_EN adds the 32-bit counters br_count
// (taken branches, excluding returns) and ret_count (successful returns).
// With the macro undefined neither the ports nor the counters exist.

module pc_fetch_ctrl #(
    parameter int unsigned            ADDR_W      = 64,
    parameter int unsigned            COND_W      = 19,
    parameter int unsigned            UNCOND_W    = 26,
    parameter int unsigned            INSTR_SHIFT = 2,
    parameter int unsigned            RAS_DEPTH   = 4,
    parameter logic [ADDR_W-1:0]      RESET_PC    = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                brTaken,
    input  logic                uncondBr,
    input  logic                link,
    input  logic                ret,
    input  logic [COND_W-1:0]   condAddr19,
    input  logic [UNCOND_W-1:0] brAddr26,
    output logic [ADDR_W-1:0]   pc,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_underflow
`ifdef BR_STATS_EN
    ,
    output logic [31:0]         br_count,
    output logic [31:0]         ret_count
`endif
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    // One extra bit so the count can represent a completely full stack.
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] INSTR_BYTES = {{(ADDR_W-1){1'b0}}, 1'b1} << INSTR_SHIFT;
    localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE     = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              udf_q, udf_d;
    logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_mem_d [RAS_DEPTH];

    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] cond_ext;
    logic [ADDR_W-1:0] uncond_ext;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] ras_top;
    logic              empty_w;
    logic              full_w;

    assign empty_w = (cnt_q == '0);
    assign full_w  = (cnt_q == DEPTH_CNT);

    always_comb begin
        seq        = pc_q + INSTR_BYTES;
        cond_ext   = {{(ADDR_W-COND_W){condAddr19[COND_W-1]}}, condAddr19};
        uncond_ext = {{(ADDR_W-UNCOND_W){brAddr26[UNCOND_W-1]}}, brAddr26};
        off        = (uncondBr ? uncond_ext : cond_ext) << INSTR_SHIFT;
        // The pointer addresses the next free slot, so the top is one below.
        ras_top    = ras_mem_q[ptr_q - PTR_ONE];
    end

    always_comb begin
        pc_d      = pc_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        udf_d     = 1'b0;
        ras_mem_d = ras_mem_q;

        if (!stall) begin
            if (ret) begin
                if (!empty_w) begin
                    pc_d  = ras_top;
                    ptr_d = ptr_q - PTR_ONE;
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    pc_d  = seq;
                    udf_d = 1'b1;
                end
            end else if (brTaken) begin
                pc_d = pc_q + off;
                if (uncondBr && link) begin
                    // When full, the write lands on the oldest entry and the
                    // count saturates: the stack keeps the newest entries.
                    ras_mem_d[ptr_q] = seq;
                    ptr_d            = ptr_q + PTR_ONE;
                    cnt_d            = full_w ? cnt_q : cnt_q + CNT_ONE;
                end
            end else begin
                pc_d = seq;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            ptr_q <= '0;
            cnt_q <= '0;
            udf_q <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            udf_q     <= udf_d;
            ras_mem_q <= ras_mem_d;
        end
    end

    assign pc            = pc_q;
    assign ras_empty     = empty_w;
    assign ras_full      = full_w;
    assign ras_underflow = udf_q;

`ifdef BR_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] ret_cnt_q, ret_cnt_d;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        ret_cnt_d = ret_cnt_q;
        if (!stall && brTaken && !ret) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (!stall && ret && !empty_w) begin
            ret_cnt_d = ret_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_cnt_q  <= '0;
            ret_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign br_count  = br_cnt_q;
    assign ret_count = ret_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, brTaken, uncondBr, link, ret;
    logic [18:0] condAddr19;
    logic [25:0] brAddr26;
    logic [63:0] pc;
    logic        ras_empty, ras_full, ras_underflow;
`ifdef BR_STATS_EN
    logic [31:0] br_count, ret_count;
`endif

    pc_fetch_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .brTaken       (brTaken),
        .uncondBr      (uncondBr),
        .link          (link),
        .ret           (ret),
        .condAddr19    (condAddr19),
        .brAddr26      (brAddr26),
        .pc            (pc),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow)
`ifdef BR_STATS_EN
        ,
        .br_count      (br_count),
        .ret_count     (ret_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic        empty;
        logic        full;
        logic        udf;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void compare(string nm, logic [63:0] epc, logic ee, logic ef, logic eu);
        n_tests++;
        if (pc !== epc || ras_empty !== ee || ras_full !== ef || ras_underflow !== eu) begin
            n_fail++;
            $display("FAIL %s: got pc=%h empty=%b full=%b udf=%b, expected pc=%h empty=%b full=%b udf=%b",
                     nm, pc, ras_empty, ras_full, ras_underflow, epc, ee, ef, eu);
        end
    endfunction

    // Monitor: every registered update is checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare(e.name, e.pc, e.empty, e.full, e.udf);
            end
        end
    end

    // Drive one cycle of inputs on the falling edge and queue the state
    // expected after the following rising edge.
    task automatic step(input logic st, bt, ub, lk, rt,
                        input logic [18:0] c, input logic [25:0] b,
                        input logic [63:0] epc, input logic ee, ef, eu,
                        input string nm);
        exp_t e;
        @(negedge clk);
        stall = st; brTaken = bt; uncondBr = ub; link = lk; ret = rt;
        condAddr19 = c; brAddr26 = b;
        e.pc = epc; e.empty = ee; e.full = ef; e.udf = eu; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [63:0] epc, input logic ee, ef, eu, input string nm);
        step(0, 0, 0, 0, 0, 19'd0, 26'd0, epc, ee, ef, eu, nm);
    endtask

    task automatic bl(input logic [25:0] b, input logic [63:0] epc, input logic ef, input string nm);
        step(0, 1, 1, 1, 0, 19'd0, b, epc, 1'b0, ef, 1'b0, nm);
    endtask

    task automatic rett(input logic [63:0] epc, input logic ee, ef, eu, input string nm);
        step(0, 0, 0, 0, 1, 19'd0, 26'd0, epc, ee, ef, eu, nm);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        stall = 0; brTaken = 0; uncondBr = 0; link = 0; ret = 0;
        condAddr19 = '0; brAddr26 = '0;
        #2;
        compare("reset_state", 64'd0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        compare("reset_held", 64'd0, 1'b1, 1'b0, 1'b0);

        // Sequential fetch
        @(negedge clk);
        reset = 1'b1;
        begin
            exp_t e;
            e.pc = 64'd4; e.empty = 1; e.full = 0; e.udf = 0; e.name = "seq_4";
            exp_q.push_back(e);
        end
        idle(64'd8,  1, 0, 0, "seq_8");
        idle(64'd12, 1, 0, 0, "seq_12");

        // Unconditional +3 words, conditional -2 words
        step(0, 1, 1, 0, 0, 19'd0, 26'd3, 64'd24, 1, 0, 0, "uncond_fwd");
        step(0, 1, 0, 0, 0, 19'h7FFFE, 26'd0, 64'd16, 1, 0, 0, "cond_back");

        // Stall holds the PC even with a branch pending
        step(1, 1, 1, 0, 0, 19'd0, 26'd5, 64'd16, 1, 0, 0, "stall_1");
        step(1, 1, 1, 0, 0, 19'd0, 26'd5, 64'd16, 1, 0, 0, "stall_2");
        step(0, 1, 1, 0, 0, 19'd0, 26'd5, 64'd36, 1, 0, 0, "stall_release");

        // Branch-with-link then return
        bl(26'd10, 64'd76, 1'b0, "bl_push");
        rett(64'd40, 1, 0, 0, "ret_pop");

        // Return on empty stack: fall through and flag underflow for one cycle
        rett(64'd44, 1, 0, 1, "ret_underflow");
        idle(64'd48, 1, 0, 0, "underflow_clear");

        // Return beats branch/link in the same cycle
        bl(26'd2, 64'd56, 1'b0, "bl_push2");
        step(0, 1, 1, 1, 1, 19'd0, 26'd100, 64'd52, 1, 0, 0, "ret_over_branch");

        // Stalled return on empty stack: no underflow, PC holds
        step(1, 0, 0, 0, 1, 19'd0, 26'd0, 64'd52, 1, 0, 0, "stall_ret_empty");

        // Five links into a four-deep stack overwrite the oldest entry
        bl(26'd1, 64'd56, 1'b0, "bl_a1");
        bl(26'd1, 64'd60, 1'b0, "bl_a2");
        bl(26'd1, 64'd64, 1'b0, "bl_a3");
        bl(26'd1, 64'd68, 1'b1, "bl_a4_full");
        bl(26'd1, 64'd72, 1'b1, "bl_a5_overwrite");
        rett(64'd72, 0, 0, 0, "pop_a5");
        rett(64'd68, 0, 0, 0, "pop_a4");
        rett(64'd64, 0, 0, 0, "pop_a3");
        rett(64'd60, 1, 0, 0, "pop_a2");
        rett(64'd64, 1, 0, 1, "pop_underflow");
        idle(64'd68, 1, 0, 0, "after_underflow");

        // Asynchronous reset in the middle of pops discards the stack
        bl(26'd1, 64'd72, 1'b0, "bl_b1");
        bl(26'd1, 64'd76, 1'b0, "bl_b2");
        rett(64'd76, 0, 0, 0, "pop_b2");
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        compare("async_reset_midpop", 64'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        compare("reset_hold_midpop", 64'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        stall = 0; brTaken = 1; uncondBr = 0; link = 0; ret = 0;
        condAddr19 = 19'h7FFFE; brAddr26 = '0;
        begin
            exp_t e;
            // 0 - 8 wraps to 2^64 - 8
            e.pc = 64'hFFFF_FFFF_FFFF_FFF8; e.empty = 1; e.full = 0; e.udf = 0;
            e.name = "wrap_back";
            exp_q.push_back(e);
        end
        rett(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 1, "stack_cleared");
        idle(64'd0, 1, 0, 0, "wrap_seq");

        begin
            int budget = 0;
            while (exp_q.size() > 0 && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            @(posedge clk);
            #2;
            n_tests++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
